data_mem_responder: RTL and testbench

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

---
 rtl/data_mem_responder.sv | 107 ++++++++++
 tb/tb_data_mem_responder.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// Single-outstanding load/store responder over a DEPTH x 16-bit word memory.
// Each request waits WAIT_CYCLES before its response, which is held until consumed.
module data_mem_responder #(
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        req_ready,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic        wr_q;
  logic [15:0] addr_q;
  logic [15:0] wdata_q;
  logic [15:0] mem [DEPTH];

  // With zero wait states the response is formed on the acceptance edge,
  // before the request registers hold anything, so the live inputs are used.
  logic          op_write;
  logic [15:0]   op_addr;
  logic [15:0]   op_wdata;
  logic          op_in_range;
  logic [AW-1:0] op_idx;
  logic          enter_resp;
  logic [15:0]   rd_nxt;

  assign op_write    = (state == IDLE) ? req_write : wr_q;
  assign op_addr     = (state == IDLE) ? req_addr  : addr_q;
  assign op_wdata    = (state == IDLE) ? req_wdata : wdata_q;
  assign op_in_range = {1'b0, op_addr} < 17'(DEPTH);
  assign op_idx      = op_addr[AW-1:0];
  assign rd_nxt      = (!op_write && op_in_range) ? mem[op_idx] : 16'h0000;

  assign enter_resp = ((state == IDLE) && req_valid && (WAIT_CYCLES == 0)) ||
                      ((state == WAIT) && (cnt == 4'd1));

  // Memory is never reset; the write is suppressed while reset is held so an
  // aborted store cannot land.
  always_ff @(posedge clk) begin
    if (reset && enter_resp && op_write && op_in_range)
      mem[op_idx] <= op_wdata;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      wr_q      <= 1'b0;
      addr_q    <= 16'h0000;
      wdata_q   <= 16'h0000;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= 16'h0000;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          wr_q      <= req_write;
          addr_q    <= req_addr;
          wdata_q   <= req_wdata;
          cnt       <= 4'(WAIT_CYCLES);
          req_ready <= 1'b0;
          if (WAIT_CYCLES == 0) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_err   <= !op_in_range;
            rsp_rdata <= rd_nxt;
          end else begin
            state <= WAIT;
          end
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_err   <= !op_in_range;
            rsp_rdata <= rd_nxt;
          end
        end
        RESP: if (rsp_ready) begin
          state     <= IDLE;
          req_ready <= 1'b1;
          rsp_valid <= 1'b0;
          rsp_err   <= 1'b0;
          rsp_rdata <= 16'h0000;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Two responders (WAIT_CYCLES=2 and 0) driven with directed and random traffic,
// checked every cycle against a transaction-level model plus literal expectations.
module tb_data_mem_responder;

  localparam int WC [2] = '{2, 0};

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req_valid, req_write, req_ready, rsp_valid, rsp_ready, rsp_err;
  logic [15:0] req_addr [2];
  logic [15:0] req_wdata [2];
  logic [15:0] rsp_rdata [2];

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    data_mem_responder #(.DEPTH(256), .WAIT_CYCLES(WC[g])) u_dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid[g]), .req_write(req_write[g]),
      .req_addr(req_addr[g]), .req_wdata(req_wdata[g]),
      .req_ready(req_ready[g]), .rsp_valid(rsp_valid[g]),
      .rsp_ready(rsp_ready[g]), .rsp_rdata(rsp_rdata[g]), .rsp_err(rsp_err[g])
    );
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic bad(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: bound expired (t=%0t)", nm, $time);
  endtask

  // Transaction model: a request is busy from acceptance, answers WAIT edges
  // later, and is retired on the handshake edge.
  bit          m_busy [2] = '{0, 0};
  bit          m_resp [2] = '{0, 0};
  bit          m_err  [2];
  bit          m_wr   [2];
  int          m_left [2];
  logic [15:0] m_a [2];
  logic [15:0] m_d [2];
  logic [15:0] m_rd [2];
  logic [15:0] mmem [2][256];

  always @(posedge clk or negedge reset) begin
    for (int i = 0; i < 2; i++) begin
      if (!reset) begin
        m_busy[i] <= 1'b0;
        m_resp[i] <= 1'b0;
        m_left[i] <= 0;
      end else if (m_resp[i]) begin
        if (rsp_ready[i]) begin
          m_resp[i] <= 1'b0;
          m_busy[i] <= 1'b0;
        end
      end else if (m_busy[i]) begin
        if (m_left[i] > 1) m_left[i] <= m_left[i] - 1;
        else begin
          m_resp[i] <= 1'b1;
          m_err[i]  <= (m_a[i] >= 16'd256);
          m_rd[i]   <= (!m_wr[i] && m_a[i] < 16'd256) ? mmem[i][m_a[i][7:0]] : 16'h0000;
          if (m_wr[i] && m_a[i] < 16'd256) mmem[i][m_a[i][7:0]] <= m_d[i];
        end
      end else if (req_valid[i]) begin
        m_busy[i] <= 1'b1;
        m_wr[i]   <= req_write[i];
        m_a[i]    <= req_addr[i];
        m_d[i]    <= req_wdata[i];
        m_left[i] <= WC[i];
        if (WC[i] == 0) begin
          m_resp[i] <= 1'b1;
          m_err[i]  <= (req_addr[i] >= 16'd256);
          m_rd[i]   <= (!req_write[i] && req_addr[i] < 16'd256) ?
                       mmem[i][req_addr[i][7:0]] : 16'h0000;
          if (req_write[i] && req_addr[i] < 16'd256)
            mmem[i][req_addr[i][7:0]] <= req_wdata[i];
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("u%0d_req_ready", i), 32'(req_ready[i]), 32'(!m_busy[i]));
        chk($sformatf("u%0d_rsp_valid", i), 32'(rsp_valid[i]), 32'(m_resp[i]));
        chk($sformatf("u%0d_rsp_err", i), 32'(rsp_err[i]), 32'(m_resp[i] && m_err[i]));
        chk($sformatf("u%0d_rsp_rdata", i), 32'(rsp_rdata[i]),
            32'(m_resp[i] ? m_rd[i] : 16'h0000));
      end
    end
  end

  // One request/response; in-flight cycles scramble req_* and rsp_ready.
  task automatic xact(input int i, input bit wr, input logic [15:0] a, input logic [15:0] d,
                      input int stall, output logic [15:0] rd, output bit er, output int lat);
    int n;
    int seen;
    rd = 16'h0000; er = 1'b0; lat = -1;
    @(negedge clk);
    req_valid[i] = 1'b1; req_write[i] = wr; req_addr[i] = a; req_wdata[i] = d;
    rsp_ready[i] = 1'b0;
    n = 0;
    while (!req_ready[i] && n < 50) begin @(negedge clk); n++; end
    if (!req_ready[i]) begin
      bad("accept_wait");
      req_valid[i] = 1'b0;
      return;
    end
    n = 0; seen = 0;
    do begin
      @(negedge clk); n++;
      req_valid[i] = 1'($urandom_range(0, 1));
      req_write[i] = 1'($urandom_range(0, 1));
      req_addr[i]  = 16'($urandom);
      req_wdata[i] = 16'($urandom);
      if (rsp_valid[i]) begin
        if (lat < 0) lat = n;
        seen++;
        rd = rsp_rdata[i];
        er = rsp_err[i];
        rsp_ready[i] = (seen > stall);
      end else begin
        rsp_ready[i] = 1'($urandom_range(0, 1));
      end
    end while (!(rsp_valid[i] && rsp_ready[i]) && n < 100);
    if (n >= 100) bad("response_wait");
    @(negedge clk);
    req_valid[i] = 1'b0; rsp_ready[i] = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] rd, a;
    bit er;
    int lat, last, acc;
    req_valid = '0; req_write = '0; rsp_ready = '0;
    for (int i = 0; i < 2; i++) begin req_addr[i] = '0; req_wdata[i] = '0; end
    reset = 1'b1;
    #3 reset = 1'b0;
    #1 chk("rst_req_ready", 32'(req_ready), 32'h3);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_rdata0", 32'(rsp_rdata[0]), 32'h0);
    chk_en = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // Known contents everywhere: word a = {a, ~a}.
    for (int i = 0; i < 2; i++)
      for (int k = 0; k < 256; k++) begin
        a = 16'(k);
        xact(i, 1'b1, a, {a[7:0], ~a[7:0]}, 0, rd, er, lat);
      end

    xact(0, 1'b1, 16'h0005, 16'hBEEF, 0, rd, er, lat);
    chk("st_latency", 32'(lat), 32'd3);
    chk("st_err", 32'(er), 32'd0);
    chk("st_rdata", 32'(rd), 32'h0);
    xact(0, 1'b0, 16'h0005, 16'h0000, 1, rd, er, lat);
    chk("raw_load_beef", 32'(rd), 32'hBEEF);
    chk("model_mem5", 32'(mmem[0][5]), 32'hBEEF);

    xact(0, 1'b0, 16'h0100, 16'h0000, 0, rd, er, lat);
    chk("oor_err", 32'(er), 32'd1);
    chk("oor_rdata", 32'(rd), 32'h0);
    xact(0, 1'b1, 16'h0105, 16'h1111, 0, rd, er, lat);
    chk("oor_store_err", 32'(er), 32'd1);
    xact(0, 1'b0, 16'h0005, 16'h0000, 0, rd, er, lat);
    chk("no_alias_5", 32'(rd), 32'hBEEF);
    xact(0, 1'b0, 16'h0000, 16'h0000, 0, rd, er, lat);
    chk("word0_intact", 32'(rd), 32'h00FF);

    xact(1, 1'b0, 16'h0007, 16'h0000, 0, rd, er, lat);
    chk("w0_latency", 32'(lat), 32'd1);
    chk("w0_load", 32'(rd), 32'h07F8);

    xact(0, 1'b1, 16'h0010, 16'hC3C3, 5, rd, er, lat);
    chk("stall_latency", 32'(lat), 32'd3);
    xact(0, 1'b0, 16'h0010, 16'h0000, 5, rd, er, lat);
    chk("stall_load", 32'(rd), 32'hC3C3);

    // Reset during WAIT aborts the pending store.
    @(negedge clk);
    req_valid[0] = 1'b1; req_write[0] = 1'b1; req_addr[0] = 16'h0003; req_wdata[0] = 16'h1234;
    @(negedge clk);
    req_valid[0] = 1'b0;
    chk("inflight_ready", 32'(req_ready[0]), 32'd0);
    #2 reset = 1'b0;
    #1 chk("abort_req_ready", 32'(req_ready[0]), 32'd1);
    chk("abort_rsp_valid", 32'(rsp_valid[0]), 32'd0);
    chk("abort_rsp_err", 32'(rsp_err[0]), 32'd0);
    chk("abort_rdata", 32'(rsp_rdata[0]), 32'h0);
    @(negedge clk);
    reset = 1'b1;
    xact(0, 1'b0, 16'h0003, 16'h0000, 0, rd, er, lat);
    chk("abort_no_write", 32'(rd), 32'h03FC);
    chk("model_mem3", 32'(mmem[0][3]), 32'h03FC);

    xact(0, 1'b1, 16'h00FF, 16'hA5A5, 0, rd, er, lat);
    @(negedge clk); reset = 1'b0;
    @(negedge clk); reset = 1'b1;
    xact(0, 1'b0, 16'h00FF, 16'h0000, 0, rd, er, lat);
    chk("mem_retained", 32'(rd), 32'hA5A5);

    for (int i = 0; i < 2; i++)
      for (int k = 0; k < 150; k++) begin
        case ($urandom_range(0, 9))
          0:       a = 16'($urandom);
          1:       a = 16'h0100 | 16'($urandom_range(0, 255));
          default: a = 16'($urandom_range(0, 255));
        endcase
        xact(i, 1'($urandom_range(0, 1)), a, 16'($urandom), $urandom_range(0, 3), rd, er, lat);
      end

    // Back-to-back with zero wait states: one acceptance every other edge.
    @(negedge clk);
    rsp_ready[1] = 1'b1; req_valid[1] = 1'b1; req_write[1] = 1'b0;
    last = -1; acc = 0;
    for (int k = 0; k < 12; k++) begin
      req_addr[1] = 16'($urandom_range(0, 255));
      if (req_ready[1]) begin
        if (last >= 0) chk("b2b_gap", 32'(k - last), 32'd2);
        last = k;
        acc++;
      end
      @(negedge clk);
    end
    req_valid[1] = 1'b0; rsp_ready[1] = 1'b0;
    chk("b2b_count", 32'(acc), 32'd6);
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
